serial_subtractor: RTL and testbench

Bit-serial N-bit subtractor, the inverse counterpart of the team's registered full-adder datapath. It accepts two operands and a borrow-in through a valid/ready handshake and computes A − B − Bin one bit per clock, LSB first, using a single full-subtractor cell and a borrow register. It returns the difference and the final borrow-out through a valid/ready output handshake. It is the minimal-area subtract path for control logic where latency is not critical.

---
 rtl/serial_subtractor.sv | 114 +++++++++++
 tb/tb_serial_subtractor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes A - B - Bin one bit per clock, LSB first,
// through a single full-subtractor cell and a borrow register.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             areset_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] A_i,
    input  logic [WIDTH-1:0] B_i,
    input  logic             Bin_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] D_o,
    output logic             Bout_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic [WIDTH-1:0] d_msb;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             bit_a;
    logic             bit_b;
    logic             bit_d;
    logic             brw_next;
    logic             accept;
    logic             last_bit;

    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Handshake outputs depend on state only, never on valid_i or ready_i.
    always_comb begin
        state_next = state;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept   = (state == IDLE) && valid_i;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_comb begin
        bit_a    = a_sh[0];
        bit_b    = b_sh[0];
        bit_d    = bit_a ^ bit_b ^ brw;
        brw_next = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & brw);
        d_msb    = '0;
        d_msb[WIDTH-1] = bit_d;
    end

    // Each difference bit enters at the MSB so bit 0 lands at d_sh[0] after WIDTH steps.
    always_ff @(posedge clk_i or posedge areset_i) begin
        if (areset_i) begin
            a_sh <= '0;
            b_sh <= '0;
            d_sh <= '0;
            brw  <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            a_sh <= A_i;
            b_sh <= B_i;
            brw  <= Bin_i;
            cnt  <= '0;
        end else if (state == CALC) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            d_sh <= (d_sh >> 1) | d_msb;
            brw  <= brw_next;
            cnt  <= cnt + CW'(1);
        end
    end

    assign D_o    = d_sh;
    assign Bout_o = brw;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit and a 1-bit instance, directed vectors
// checked against literal values and an arithmetic reference model.
module tb_serial_subtractor;

    typedef struct packed {
        logic [7:0] d;
        logic       bout;
    } result_t;

    logic clk = 1'b0;
    logic rst;

    logic       valid8, ready8, bin8, res_valid8, res_ready8, bout8;
    logic [7:0] a8, b8, d8;
    logic       valid1, ready1, bin1, res_valid1, res_ready1, bout1;
    logic [0:0] a1, b1, d1;

    int n_vec = 0;
    int n_mis = 0;
    int hs8 = 0;
    int hs1 = 0;
    time acc_prev8 = 0;
    time acc_last8 = 0;
    result_t exp8_q[$];
    result_t exp1_q[$];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk_i(clk), .areset_i(rst), .valid_i(valid8), .ready_o(ready8),
        .A_i(a8), .B_i(b8), .Bin_i(bin8), .valid_o(res_valid8),
        .ready_i(res_ready8), .D_o(d8), .Bout_o(bout8)
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk_i(clk), .areset_i(rst), .valid_i(valid1), .ready_o(ready1),
        .A_i(a1), .B_i(b1), .Bin_i(bin1), .valid_o(res_valid1),
        .ready_i(res_ready1), .D_o(d1), .Bout_o(bout1)
    );

    function automatic result_t model(input int a, input int b, input int bin, input int w);
        int diff;
        result_t r;
        diff   = a - b - bin;
        r.d    = 8'((diff + 512) % (1 << w));
        r.bout = (diff < 0);
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("[TB] FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Inputs change only at posedge+1, so handshakes seen here happen at the next edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid8 && ready8) begin
                exp8_q.push_back(model(a8, b8, bin8, 8));
                acc_prev8 = acc_last8;
                acc_last8 = $time + 5;
            end
            if (res_valid8) begin
                if (exp8_q.size() == 0) begin
                    check_output("spurious_valid8", 32'(res_valid8), 32'd0);
                end else begin
                    check_output("model_d8", 32'(d8), 32'(exp8_q[0].d));
                    check_output("model_bout8", 32'(bout8), 32'(exp8_q[0].bout));
                    if (res_ready8) begin
                        void'(exp8_q.pop_front());
                        hs8++;
                    end
                end
            end
            if (valid1 && ready1) begin
                exp1_q.push_back(model(a1, b1, bin1, 1));
            end
            if (res_valid1) begin
                if (exp1_q.size() == 0) begin
                    check_output("spurious_valid1", 32'(res_valid1), 32'd0);
                end else begin
                    check_output("model_d1", 32'(d1), 32'(exp1_q[0].d));
                    check_output("model_bout1", 32'(bout1), 32'(exp1_q[0].bout));
                    if (res_ready1) begin
                        void'(exp1_q.pop_front());
                        hs1++;
                    end
                end
            end
        end
    end

    task automatic drive(input int sel, input logic v, input logic [7:0] a, input logic [7:0] b, input logic bin);
        if (sel == 8) begin
            valid8 = v; a8 = a; b8 = b; bin8 = bin;
        end else begin
            valid1 = v; a1 = a[0]; b1 = b[0]; bin1 = bin;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 8) ? ready8 : ready1;
    endfunction

    function automatic logic get_valid(input int sel);
        return (sel == 8) ? res_valid8 : res_valid1;
    endfunction

    // Runs one transaction: accept, latency, literal result, optional backpressure, handshake.
    task automatic apply_stimulus(input int sel, input logic [7:0] a, input logic [7:0] b,
                                  input logic bin, input int hold, input logic busy,
                                  input logic [7:0] exp_d, input logic exp_bout, input int exp_lat);
        int cyc;
        int hs_before;
        if (sel == 8) res_ready8 = (hold == 0); else res_ready1 = (hold == 0);
        drive(sel, 1'b1, a, b, bin);
        cyc = 0;
        while (!get_ready(sel) && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        check_output("accept_ready", 32'(get_ready(sel)), 32'd1);
        @(posedge clk); #1;
        if (busy) drive(sel, 1'b1, ~a, a, ~bin);
        else drive(sel, 1'b0, 8'h00, 8'h00, 1'b0);
        cyc = 0;
        while (!get_valid(sel) && cyc < 50) begin
            @(posedge clk); #1; cyc++;
        end
        drive(sel, 1'b0, 8'h00, 8'h00, 1'b0);
        check_output("latency", 32'(cyc), 32'(exp_lat));
        check_output("busy_during_calc", 32'(get_ready(sel)), 32'd0);
        if (sel == 8) begin
            check_output("lit_d8", 32'(d8), 32'(exp_d));
            check_output("lit_bout8", 32'(bout8), 32'(exp_bout));
            hs_before = hs8;
        end else begin
            check_output("lit_d1", 32'(d1), 32'(exp_d[0]));
            check_output("lit_bout1", 32'(bout1), 32'(exp_bout));
            hs_before = hs1;
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk); #1;
                check_output("held_valid", 32'(get_valid(sel)), 32'd1);
            end
            if (sel == 8) res_ready8 = 1'b1; else res_ready1 = 1'b1;
        end
        @(posedge clk); #1;
        check_output("ready_after_hs", 32'(get_ready(sel)), 32'd1);
        check_output("valid_after_hs", 32'(get_valid(sel)), 32'd0);
        check_output("one_handshake", 32'((sel == 8) ? hs8 : hs1), 32'(hs_before + 1));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp8_q.delete();
        exp1_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0] tt_d;
        logic [7:0] tt_b;
        logic [2:0] combo;
        int cyc;
        rst = 1'b0;
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
        res_ready8 = 1'b1;
        res_ready1 = 1'b1;
        @(posedge clk); #1;
        do_reset();

        check_output("reset_ready8", 32'(ready8), 32'd1);
        check_output("reset_valid8", 32'(res_valid8), 32'd0);
        check_output("reset_d8", 32'(d8), 32'd0);
        check_output("reset_bout8", 32'(bout8), 32'd0);
        check_output("reset_ready1", 32'(ready1), 32'd1);
        check_output("reset_valid1", 32'(res_valid1), 32'd0);

        $display("[TB] basic subtraction");
        apply_stimulus(8, 8'h5A, 8'h3C, 1'b0, 0, 1'b0, 8'h1E, 1'b0, 8);

        $display("[TB] underflow and borrow-in");
        apply_stimulus(8, 8'h00, 8'h01, 1'b0, 0, 1'b0, 8'hFF, 1'b1, 8);
        apply_stimulus(8, 8'h10, 8'h0F, 1'b1, 0, 1'b0, 8'h00, 1'b0, 8);

        $display("[TB] backpressure");
        apply_stimulus(8, 8'hFF, 8'h00, 1'b1, 5, 1'b0, 8'hFE, 1'b0, 8);

        $display("[TB] busy-time request and back-to-back");
        apply_stimulus(8, 8'h80, 8'h01, 1'b0, 0, 1'b1, 8'h7F, 1'b0, 8);
        apply_stimulus(8, 8'h01, 8'h80, 1'b0, 0, 1'b0, 8'h81, 1'b1, 8);
        check_output("accept_spacing", 32'((acc_last8 - acc_prev8) / 10), 32'd10);

        $display("[TB] reset mid-calc");
        drive(8, 1'b1, 8'hAA, 8'h11, 1'b0);
        @(posedge clk); #1;
        drive(8, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        exp8_q.delete();
        #1;
        check_output("rst_async_ready8", 32'(ready8), 32'd1);
        check_output("rst_async_valid8", 32'(res_valid8), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (res_valid8) cyc++;
        end
        check_output("no_valid_after_rst", 32'(cyc), 32'd0);
        apply_stimulus(8, 8'h03, 8'h02, 1'b0, 0, 1'b0, 8'h01, 1'b0, 8);

        $display("[TB] width 1 exhaustive");
        tt_d = 8'b1001_0110;
        tt_b = 8'b1000_1110;
        for (int i = 0; i < 8; i++) begin
            combo = 3'(i);
            apply_stimulus(1, {7'd0, combo[2]}, {7'd0, combo[1]}, combo[0], 0, 1'b0,
                           {7'd0, tt_d[i]}, tt_b[i], 1);
        end

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

endmodule
